// File: rtl/alu_arb_pkg.sv
// Shared constants and request/response types for the shared-ALU arbiter.
package alu_arb_pkg;
  localparam int ALU_DATA_W  = 24;
  localparam int ALU_ID_W    = 3;
  localparam int ALU_CTRL_W  = 4;
  localparam int ALU_FLAGS_W = 2;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_CTRL_W-1:0] ctrl;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_ID_W-1:0]    id;
    logic [ALU_DATA_W-1:0]  result;
    logic [ALU_FLAGS_W-1:0] flags;
  } alu_resp_t;
endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int unsigned    ji;
  logic [IDW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    ji  = 0;
    j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      ji = (int'(start) + k) % NREQ;
      j  = IDW'(ji);
      if (en && !any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters with a single registered, tagged response stage.
// Optional ALU_ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 24,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*N-1:0]      req_a,
  input  logic [NREQ*N-1:0]      req_b,
  input  logic [NREQ*ALU_CTRL_W-1:0] req_ctrl,
  output logic [N-1:0]           alu_a,
  output logic [N-1:0]           alu_b,
  output logic [ALU_CTRL_W-1:0]  alu_ctrl,
  input  logic [N-1:0]           alu_result,
  input  logic [ALU_FLAGS_W-1:0] alu_flags,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [N-1:0]           resp_result,
  output logic [ALU_FLAGS_W-1:0] resp_flags
);
  typedef struct packed {
    logic [N-1:0]          a;
    logic [N-1:0]          b;
    logic [ALU_CTRL_W-1:0] ctrl;
  } req_t;

  typedef struct packed {
    logic [IDW-1:0]         id;
    logic [N-1:0]           result;
    logic [ALU_FLAGS_W-1:0] flags;
  } resp_t;

  req_t [NREQ-1:0] reqs;
  resp_t           resp_q, resp_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            can_issue, en, any, xfer, upd_ptr;
  logic [NREQ-1:0] pick_req, pick_gnt, gnt;
  logic [IDW-1:0]  pick_idx, gidx, sel;
  logic            pick_en, pick_any;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      reqs[i].a    = req_a[i*N +: N];
      reqs[i].b    = req_b[i*N +: N];
      reqs[i].ctrl = req_ctrl[i*ALU_CTRL_W +: ALU_CTRL_W];
    end
  end

  // Reset gates the grant combinationally so nothing is offered while rst is high.
  assign can_issue = !resp_valid_q || resp_ready;
  assign en        = can_issue && !rst;

`ifdef ALU_ARB_PRIO0_EN
  logic prio0;
  assign prio0    = en && req_valid[0];
  assign pick_req = req_valid & ~NREQ'(1);
  assign pick_en  = en && !req_valid[0];
  assign gnt      = prio0 ? NREQ'(1) : pick_gnt;
  assign gidx     = prio0 ? '0 : pick_idx;
  assign any      = prio0 || pick_any;
  assign upd_ptr  = !prio0;
`else
  assign pick_req = req_valid;
  assign pick_en  = en;
  assign gnt      = pick_gnt;
  assign gidx     = pick_idx;
  assign any      = pick_any;
  assign upd_ptr  = 1'b1;
`endif

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (pick_req),
    .start (rr_ptr_q),
    .en    (pick_en),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);

  // Idle cycles present rr_ptr's fields so the ALU inputs stay defined.
  assign sel      = any ? gidx : rr_ptr_q;
  assign alu_a    = reqs[sel].a;
  assign alu_b    = reqs[sel].b;
  assign alu_ctrl = reqs[sel].ctrl;

  always_comb begin
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      resp_d.id     = gidx;
      resp_d.result = alu_result;
      resp_d.flags  = alu_flags;
      resp_valid_d  = 1'b1;
      if (upd_ptr)
        rr_ptr_d = (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_q.id;
  assign resp_result = resp_q.result;
  assign resp_flags  = resp_q.flags;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter with a queue-based scoreboard.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;
  localparam int N = 24, NREQ = 4, IDW = 2;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]         v_i;
  logic [NREQ-1:0][N-1:0]  a_i, b_i;
  logic [NREQ-1:0][3:0]    c_i;
  logic                    rr_i;
  logic [NREQ-1:0]         req_ready;
  logic [N-1:0]            alu_a, alu_b, alu_result, resp_result;
  logic [3:0]              alu_ctrl;
  logic [1:0]              alu_flags, resp_flags;
  logic                    resp_valid;
  logic [IDW-1:0]          resp_id;
  logic [N:0]              alu_sum;

  alu_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(v_i), .req_ready(req_ready),
    .req_a(a_i), .req_b(b_i), .req_ctrl(c_i),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(rr_i), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags)
  );

  // ALU stand-in: sum for every select, flags = {zero, carry}
  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = alu_sum[N-1:0];
  assign alu_flags  = {alu_sum[N-1:0] == '0, alu_sum[N]};

  int        vectors = 0, miscompares = 0;
  alu_resp_t expq[$];
  int        hist[$];
  int        m_ptr = 0;
  bit        m_rv = 0;
  int        last_g = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: rotation starts after the last served requester; optional strict prio for 0.
  task automatic tick();
    int g;
    bit can;
    logic [N:0] s;
    @(negedge clk);
    can = !m_rv || rr_i;
    g = -1;
    if (can) begin
`ifdef ALU_ARB_PRIO0_EN
      if (v_i[0]) g = 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && v_i[j]) g = j;
      end
    end
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("resp_valid", 32'(resp_valid), 32'(m_rv));
    if (g >= 0) begin
      s = {1'b0, a_i[g]} + {1'b0, b_i[g]};
      expq.push_back('{id: 3'(g), result: s[N-1:0], flags: {s[N-1:0] == '0, s[N]}});
      m_rv = 1;
`ifdef ALU_ARB_PRIO0_EN
      if (g != 0) m_ptr = (g + 1) % NREQ;
`else
      m_ptr = (g + 1) % NREQ;
`endif
      hist.push_back(g);
    end else if (rr_i) begin
      m_rv = 0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  // Monitor: each consumed response must match the oldest expected one.
  always @(negedge clk) begin
    alu_resp_t e;
    if (rst === 1'b0 && resp_valid === 1'b1 && rr_i === 1'b1) begin
      if (expq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_result", 32'(resp_result), 32'(e.result));
        chk("resp_flags", 32'(resp_flags), 32'(e.flags));
      end
    end
  end

  task automatic rand_ops(input int i);
    a_i[i] = ($urandom % 8 == 0) ? {N{1'b1}} : N'($urandom);
    b_i[i] = ($urandom % 8 == 0) ? N'(1) : N'($urandom);
    c_i[i] = 4'($urandom);
  endtask

  initial begin
    int h0, cnt0, cnt2, id0;
    logic [N-1:0] r0;
    rst = 1'b1; v_i = '0; a_i = '0; b_i = '0; c_i = '0; rr_i = 1'b0;
    #12;
    v_i = 4'hF;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_resp_flags", 32'(resp_flags), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    v_i = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single requester
    v_i = 4'b0010; a_i[1] = 24'h000005; b_i[1] = 24'h000003; rr_i = 1'b1;
    #1 chk("single_ready", 32'(req_ready), 32'b0010);
    tick();
    v_i = '0;
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_id", 32'(resp_id), 32'd1);
    chk("single_result", 32'(resp_result), 32'h8);
    tick();

    // all four continuously valid
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    v_i = 4'hF;
    h0 = hist.size();
    for (int t = 0; t < 8; t++) tick();
    for (int t = 1; t < 8; t++)
`ifdef ALU_ARB_PRIO0_EN
      chk("order_all4", 32'(hist[h0+t]), 32'd0);
`else
      chk("order_all4", 32'(hist[h0+t]), 32'((hist[h0] + t) % NREQ));
`endif
    v_i = '0; tick();

    // backpressure with two pending
    v_i = 4'b0011; rand_ops(0); rand_ops(1);
    tick();
    id0 = last_g;
    v_i = (id0 == 0) ? 4'b0010 : 4'b0001;
    rr_i = 1'b0;
    r0 = resp_result;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("bp_hold_result", 32'(resp_result), 32'(r0));
      chk("bp_hold_id", 32'(resp_id), 32'(id0));
    end
    rr_i = 1'b1;
    tick();
    chk("bp_next_grant", 32'(last_g), 32'(1 - id0));
    v_i = '0; tick();

    // wrap and flags
    v_i = 4'b0001; a_i[0] = 24'hFFFFFF; b_i[0] = 24'h000001;
    tick();
    v_i = '0;
    chk("wrap_result", 32'(resp_result), 32'h0);
    chk("wrap_flags", 32'(resp_flags), 32'b11);
    tick();

    // requesters 0 and 2 continuously valid
    v_i = 4'b0101; rand_ops(0); rand_ops(2);
    h0 = hist.size(); cnt0 = 0; cnt2 = 0;
    for (int t = 0; t < 8; t++) tick();
    for (int t = 0; t < 8; t++) if (hist[h0+t] == 0) cnt0++; else if (hist[h0+t] == 2) cnt2++;
`ifdef ALU_ARB_PRIO0_EN
    chk("prio_two_never", 32'(cnt2), 32'd0);
`else
    chk("alt_two_count", 32'(cnt2), 32'd4);
`endif
    chk("alt_zero_count", 32'(cnt0), 32'(8 - cnt2));
    v_i = '0; tick();

    // reset while a response is held
    v_i = 4'b0100; rr_i = 1'b0;
    tick();
    v_i = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_req_ready_hold", 32'(req_ready), 32'd0);
    v_i = '0;
    @(negedge clk); rst = 1'b0;
    expq.delete(); m_rv = 0; m_ptr = 0;
    @(posedge clk); #1;
    v_i = 4'hF; rr_i = 1'b1;
    h0 = hist.size();
    tick();
    chk("first_after_rst", 32'(hist[h0]), 32'd0);
    v_i = '0; tick();

    // randomized traffic obeying the hold-until-granted rule
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v_i[i] && last_g != i) begin
          if ($urandom % 16 == 0) v_i[i] = 1'b0;
        end else begin
          v_i[i] = 1'($urandom);
          rand_ops(i);
        end
      end
      rr_i = ($urandom % 4) != 0;
      tick();
    end

    v_i = '0; rr_i = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance among NREQ requesters, e.g. vector lanes or a scalar unit plus lanes.
- Round-robin arbitration with a valid/ready handshake on each requester.
- Drives the ALU operand/select inputs combinationally from the granted request.
- Registers the ALU result and flags into a single tagged response stage with backpressure; sits between issue logic and the ALU/mux datapath.

Parameters:
- N, 24, operand/result width
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester-ID width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; at most one bit set
- req_a  in  NREQ*N  operand A, requester i at [i*N +: N]
- req_b  in  NREQ*N  operand B, same packing
- req_ctrl  in  NREQ*4  ALU select, requester i at [i*4 +: 4]
- alu_a  out  N  operand A to ALU
- alu_b  out  N  operand B to ALU
- alu_ctrl  out  4  ALU select to ALU
- alu_result  in  N  ALU combinational result
- alu_flags  in  2  ALU combinational flags
- resp_valid  out  1  response stage holds a result
- resp_ready  in  1  consumer accepts the response
- resp_id  out  IDW  requester index of the response
- resp_result  out  N  registered result
- resp_flags  out  2  registered flags

Behaviour:
- Reset (async, rst=1):
  - resp_valid=0, resp_id=0, resp_result=0, resp_flags=0.
  - rr_ptr=0.
  - req_ready=0 for the whole time rst is high.
- can_issue = !resp_valid | resp_ready.
- Arbitration (combinational):
  - If can_issue, scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first one with req_valid=1 is granted: req_ready[g]=1.
  - Otherwise req_ready=0.
- A transfer occurs when req_valid[g] & req_ready[g].
- ALU drive:
  - alu_a/alu_b/alu_ctrl = operands and select of granted requester g.
  - With no grant they show requester rr_ptr's fields (don't-care, but stable; no X).
- On a transfer at edge k:
  - resp_result<=alu_result, resp_flags<=alu_flags, resp_id<=g, resp_valid<=1.
  - rr_ptr<=(g+1) mod NREQ.
  - Latency from transfer to resp_valid is 1 cycle.
- No transfer and resp_valid & resp_ready: resp_valid<=0, other response fields hold.
- Simultaneous consume and new transfer: the new result replaces the old one, resp_valid stays 1. This gives full throughput of 1 op/cycle.
- resp_valid=1 & resp_ready=0: can_issue=0, no grant, response fields held stable.
- rr_ptr changes only on a transfer. An idle cycle does not advance it.
- Requester rules:
  - A requester must hold req_a/b/ctrl stable while req_valid=1 and not yet granted.
  - Dropping req_valid before grant is allowed; that requester is skipped.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Reset asserted mid-stream discards the pending response; no grant is issued during reset.

Optional Feature:
- Macro ALU_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority: if req_valid[0] & can_issue, grant 0 regardless of rr_ptr.
  - rr_ptr is not updated on a requester-0 grant.
  - Other requesters still round-robin among themselves.
  - Used for scalar/branch ops.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package alu_arb_pkg holds:
  - ALU_CTRL_W=4, ALU_FLAGS_W=2.
  - typedef alu_req_t {a, b, ctrl}.
  - typedef alu_resp_t {id, result, flags}.
- One natural sub-module: rr_pick.
  - Parameter NREQ.
  - Inputs: request vector, start pointer, enable.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational; the sequential state lives in the top.

Test Plan:
- The bench ALU model returns alu_result=alu_a+alu_b and flags={zero, carry} for every select.
- Reset mid-operation:
  - Stimulus: assert rst with resp_valid=1.
  - Required: resp_valid=0 immediately (async); req_ready=0 while rst high; after release, first grant starts at requester 0.
- Single requester:
  - Stimulus: req_valid=4'b0010, a=24'h000005, b=24'h000003, resp_ready=1.
  - Required: req_ready=4'b0010 same cycle; next cycle resp_valid=1, resp_id=1, resp_result=24'h000008.
- All four valid continuously with resp_ready=1:
  - Required: grant order 0,1,2,3,0,...; one response per cycle; resp_id sequence matches.
- Backpressure:
  - Stimulus: resp_ready=0 while 2 requests are pending.
  - Required: first result held stable, req_ready=0 throughout; resp_ready=1 for one cycle gives consume and next grant in the same cycle.
- Wrap and flags:
  - Stimulus: a=24'hFFFFFF, b=24'h000001.
  - Required: resp_result=24'h000000, flags reflect zero/carry from the model.
- With ALU_ARB_PRIO0_EN, requesters 0 and 2 continuously valid:
  - Required: 0 is granted every cycle and 2 is never granted.
- Without ALU_ARB_PRIO0_EN, same stimulus:
  - Required: grants alternate 0,2,0,2.
